// File: rtl/led_pattern_arbiter_if.sv
// Request/pattern bus between LED requesters and led_pattern_arbiter.
// The master side drives requests and patterns; the slave (arbiter) drives grant, busy and led.
interface led_pattern_arbiter_if;
  logic [3:0] req;
  logic [7:0] mode;
  logic [3:0] grant;
  logic       busy;
  logic       led;

  modport master (
    output req,
    output mode,
    input  grant,
    input  busy,
    input  led
  );

  modport slave (
    input  req,
    input  mode,
    output grant,
    output busy,
    output led
  );
endinterface

// File: rtl/led_pattern_arbiter.sv
// Four-requester LED blink arbiter: the owner's pattern is locked for one full period.
// Define BLINK_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req[0] first).
module led_pattern_arbiter #(
  parameter int unsigned PERIOD = 100_000_000
) (
  input logic                  clk,
  input logic                  rst,
  led_pattern_arbiter_if.slave bus
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast    = CntW'(PERIOD - 1);
  localparam logic [CntW-1:0] CntHalf    = CntW'(PERIOD / 2);
  localparam logic [CntW-1:0] CntQuarter = CntW'(PERIOD / 4);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      grant_q;
  logic [1:0]      mode_q;
  logic [3:0]      win_oh;
  logic [1:0]      win_idx;
  logic            led;

`ifdef BLINK_ARB_RR_EN
  logic [1:0] last_q;

  // Descending scan so the requester closest to last_q + 1 is the final assignment.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    win_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_q + 2'(k) + 2'd1;
      if (bus.req[idx]) win_idx = idx;
    end
    win_oh = (|bus.req) ? (4'b0001 << win_idx) : 4'b0000;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) win_idx = 2'(k);
    end
    win_oh = (|bus.req) ? (4'b0001 << win_idx) : 4'b0000;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= '0;
      mode_q  <= 2'b00;
`ifdef BLINK_ARB_RR_EN
      last_q  <= 2'd3;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (|bus.req) begin
            state_q <= StActive;
            grant_q <= win_oh;
            mode_q  <= bus.mode[{win_idx, 1'b0} +: 2];
`ifdef BLINK_ARB_RR_EN
            last_q  <= win_idx;
`endif
          end
        end
        StActive: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (|bus.req) begin
              grant_q <= win_oh;
              mode_q  <= bus.mode[{win_idx, 1'b0} +: 2];
`ifdef BLINK_ARB_RR_EN
              last_q  <= win_idx;
`endif
            end else begin
              state_q <= StIdle;
              grant_q <= '0;
              mode_q  <= 2'b00;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          grant_q <= '0;
          mode_q  <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    led = 1'b0;
    if (state_q == StActive) begin
      unique case (mode_q)
        2'b00: led = 1'b0;
        2'b01: led = 1'b1;
        2'b10: led = (cnt_q < CntHalf);
        2'b11: led = (cnt_q < CntQuarter);
        default: led = 1'b0;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = |grant_q;
  assign bus.led   = led;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed self-checking bench for led_pattern_arbiter with PERIOD = 8.
module tb_led_pattern_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  led_pattern_arbiter_if bus_if ();

  led_pattern_arbiter #(
    .PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, {4'b0, bus_if.grant}, 8'h00);
    chk({tag, ".busy"}, {7'b0, bus_if.busy}, 8'h00);
    chk({tag, ".led"}, {7'b0, bus_if.led}, 8'h00);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.req  = 4'b1111;
    bus_if.mode = 8'h55;

    // Reset wins over simultaneous requests.
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    bus_if.req = 4'b0000;
    @(negedge clk);
    chk_idle("post_reset");

    // Long pattern from idle: 4 on, 4 off, then idle.
    bus_if.req  = 4'b0001;
    bus_if.mode = 8'b0000_0010;
    @(negedge clk);
    chk("long.grant", {4'b0, bus_if.grant}, 8'h01);
    chk("long.busy", {7'b0, bus_if.busy}, 8'h01);
    bus_if.req = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("long.led%0d", k), {7'b0, bus_if.led}, (k < 4) ? 8'h01 : 8'h00);
      @(negedge clk);
    end
    chk_idle("long.end");

    // Short pattern, owner drops req at cnt=2 but keeps the period.
    bus_if.req  = 4'b0001;
    bus_if.mode = 8'b0000_0011;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("short.led%0d", k), {7'b0, bus_if.led}, (k < 2) ? 8'h01 : 8'h00);
      chk($sformatf("short.grant%0d", k), {4'b0, bus_if.grant}, 8'h01);
      if (k == 2) bus_if.req = 4'b0000;
      @(negedge clk);
    end
    chk_idle("short.end");

    // Mode change mid-period is ignored until the next period.
    bus_if.req  = 4'b0001;
    bus_if.mode = 8'b0000_0001;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lock.led%0d", k), {7'b0, bus_if.led}, 8'h01);
      if (k == 3) bus_if.mode = 8'b0000_0000;
      @(negedge clk);
    end
    chk("lock.next_led", {7'b0, bus_if.led}, 8'h00);
    chk("lock.next_busy", {7'b0, bus_if.busy}, 8'h01);
    chk("lock.next_grant", {4'b0, bus_if.grant}, 8'h01);
    bus_if.req = 4'b0000;
    repeat (8) @(negedge clk);
    chk_idle("lock.end");

    // Contention between requesters 1 and 3 over three periods.
    bus_if.req  = 4'b1010;
    bus_if.mode = 8'h55;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
`ifdef BLINK_ARB_RR_EN
      chk($sformatf("cont.grant%0d", p), {4'b0, bus_if.grant}, (p == 1) ? 8'h08 : 8'h02);
`else
      chk($sformatf("cont.grant%0d", p), {4'b0, bus_if.grant}, 8'h02);
`endif
      chk($sformatf("cont.led%0d", p), {7'b0, bus_if.led}, 8'h01);
      if (p == 2) bus_if.req = 4'b0000;
      repeat (8) @(negedge clk);
    end
    chk_idle("cont.end");

    // Reset at cnt=5 aborts the period and restores the round-robin pointer.
    bus_if.req = 4'b0001;
    @(negedge clk);
    chk("rst_mid.grant_pre", {4'b0, bus_if.grant}, 8'h01);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus_if.req = 4'b1111;
    @(negedge clk);
    chk_idle("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.first", {4'b0, bus_if.grant}, 8'h01);
    chk("rst_mid.led", {7'b0, bus_if.led}, 8'h01);
    repeat (8) @(negedge clk);
`ifdef BLINK_ARB_RR_EN
    chk("rst_mid.second", {4'b0, bus_if.grant}, 8'h02);
`else
    chk("rst_mid.second", {4'b0, bus_if.grant}, 8'h01);
`endif
    bus_if.req = 4'b0000;
    repeat (8) @(negedge clk);
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pattern_arbiter.md
LED_PATTERN_ARBITER -- requirements
Module: led_pattern_arbiter

Interface
REQ-001 Parameter PERIOD, default 100_000_000, is the clock cycles per blink period (1 s at 100 MHz); legal values are integers >= 4 and divisible by 4.
REQ-002 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req, input, 4 bits: req[i] high means requester i asks to drive the LED.
REQ-005 Port mode, input, 8 bits: mode[2i+1:2i] is the pattern for requester i (00 off, 01 solid, 10 long, 11 short).
REQ-006 Port grant, output, 4 bits: one-hot owner of the LED, or all zero when idle.
REQ-007 Port busy, output, 1 bit: high while a grant is active.
REQ-008 Port led, output, 1 bit: the LED drive.

Function
REQ-009 The block SHALL implement two states, IDLE and ACTIVE, plus a period counter cnt of width clog2(PERIOD).
REQ-010 In IDLE, cnt SHALL be held at 0, led SHALL be 0 and grant SHALL be 0.
REQ-011 In IDLE with req != 0 at edge n, the block SHALL select one winner, latch its mode, set grant and busy, and enter ACTIVE with cnt=0, all visible at n+1.
REQ-012 In ACTIVE, cnt SHALL increment every cycle and wrap from PERIOD-1 to 0.
REQ-013 In ACTIVE, led SHALL follow the latched mode combinationally from cnt:
  - off: 0
  - solid: 1
  - long: cnt < PERIOD/2
  - short: cnt < PERIOD/4
REQ-014 The grant and latched mode SHALL stay locked for a whole period; changes to req or mode before cnt = PERIOD-1 SHALL have no effect.
REQ-015 At cnt = PERIOD-1 with req != 0, the block SHALL re-arbitrate, load the new winner and mode, and continue in ACTIVE with cnt=0 on the next cycle, with no idle gap.
REQ-016 At cnt = PERIOD-1 with req == 0, the block SHALL enter IDLE on the next cycle, with grant=0, busy=0 and led=0.
REQ-017 If the owner deasserts req mid-period, the pattern SHALL still complete the period; the owner is not released early.
REQ-018 The grant SHALL always be one-hot or zero, and busy SHALL equal |grant.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL force IDLE, cnt=0, grant=0, busy=0, latched mode=00 and the round-robin pointer to "last granted = 3", overriding any operation in progress.
REQ-020 Reset SHALL take priority over simultaneous req activity; the first grant SHALL occur no earlier than one cycle after rst deasserts.

Configuration
REQ-021 With macro BLINK_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at index (last granted + 1) mod 4, and the pointer updates on every grant.
REQ-022 Without BLINK_ARB_RR_EN, arbitration SHALL be fixed priority with req[0] highest and req[3] lowest, and the pointer logic SHALL be absent.

Verification (PERIOD=8)
REQ-023 Idle start: req=0001, mode[1:0]=10 in IDLE -> next cycle grant=0001, busy=1, led=1 for 4 cycles then 0 for 4 cycles.
REQ-024 Lock: owner 0 in short mode, req[0] drops at cnt=2 -> led=1 for cnt 0-1, 0 for cnt 2-7, then IDLE and grant=0 on the following cycle.
REQ-025 Contention: req=1010 held -> fixed build grants 0010 every period; RR build alternates 0010, 1000, 0010.
REQ-026 Mode change mid-period: mode[1:0] changes 01 -> 00 at cnt=3 -> led stays 1 through cnt=7 and goes 0 from the next period.
REQ-027 Reset mid-operation: rst at cnt=5 in ACTIVE -> next cycle grant=0, busy=0, led=0, cnt=0; in the RR build, req=1111 afterwards grants 0001 first.
